// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor. One accepted start latches a and b, then the
//   difference is produced one bit per clock, LSB first, through a single
//   full-subtractor cell. A one-cycle done pulse marks the completed result.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   start      : begin one subtraction (honoured only while idle)
//   a, b       : minuend / subtrahend, sampled on the accepting edge only
//   busy       : high while bits are being processed
//   done       : one-cycle pulse, result valid
//   diff       : a - b modulo 2^WIDTH
//   borrow_out : final borrow (unsigned a < b)
//   ovf        : two's-complement overflow of a - b
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   // Counter only ever needs to reach WIDTH-1.
   localparam int CNT_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bin_q, bin_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             nb_bit;

   // Full-subtractor cell on the bit currently selected by the counter.
   always_comb begin
      a_bit  = a_q[cnt_q];
      b_bit  = b_q[cnt_q];
      d_bit  = a_bit ^ b_bit ^ bin_q;
      nb_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      bin_d    = bin_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               bin_d   = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            diff_d[cnt_q] = d_bit;
            bin_d         = nb_bit;
            if (cnt_q == LAST_BIT) begin
               // Sign bit just produced: overflow only when operand signs
               // differ and the result sign disagrees with the minuend.
               borrow_d = nb_bit;
               ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         bin_q    <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         bin_q    <= bin_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy       = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). A cycle model tracks
//   the expected IDLE/RUN/DONE phase; every accepted start pushes the expected
//   result to a queue which is popped when the done pulse is due.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         ovf;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] diff;
      logic         br;
      logic         ovf;
   } exp_t;

   exp_t q[$];
   exp_t last;

   int n_vec;
   int n_bad;

   // Model phase: 0 idle, 1 run, 2 done
   int   m_state;
   int   m_cnt;
   logic armed;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      int   sd;
      sd     = int'($signed(x)) - int'($signed(y));
      e.diff = x - y;
      e.br   = (x < y);
      e.ovf  = (sd > 127) || (sd < -128);
      return e;
   endfunction

   // Checks the current cycle at the falling edge, then advances the model by
   // what the next rising edge will do with the inputs now being presented.
   always @(negedge clk) begin
      exp_t e;
      if (armed) begin
         check("busy", 32'(busy), 32'(m_state == 1));
         check("done", 32'(done), 32'(m_state == 2));
         if (m_state == 2) begin
            if (q.size() == 0) begin
               check("done_unexpected", 32'(1), 32'(0));
            end else begin
               e = q.pop_front();
               check("diff", 32'(diff), 32'(e.diff));
               check("borrow_out", 32'(borrow_out), 32'(e.br));
               check("ovf", 32'(ovf), 32'(e.ovf));
               last = e;
            end
         end else if (m_state == 0) begin
            check("hold_diff", 32'(diff), 32'(last.diff));
            check("hold_borrow", 32'(borrow_out), 32'(last.br));
            check("hold_ovf", 32'(ovf), 32'(last.ovf));
         end
      end

      if (!rst_n) begin
         m_state   = 0;
         m_cnt     = 0;
         q.delete();
         last.diff = '0;
         last.br   = 1'b0;
         last.ovf  = 1'b0;
         armed     = 1'b1;
      end else begin
         case (m_state)
            0: if (start) begin
                  q.push_back(model(a, b));
                  m_state = 1;
                  m_cnt   = 0;
               end
            1: if (m_cnt == W - 1) m_state = 2;
               else m_cnt++;
            default: m_state = 0;
         endcase
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
      a     = x;
      b     = y;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      a     = ~x;
      b     = ~y;
      cyc(W + 2);
   endtask

   initial begin
      n_vec   = 0;
      n_bad   = 0;
      m_state = 0;
      m_cnt   = 0;
      armed   = 1'b0;
      rst_n   = 1'b0;
      start   = 1'b1;   // must be discarded while in reset
      a       = 8'h12;
      b       = 8'h34;
      cyc(2);
      start   = 1'b0;
      rst_n   = 1'b1;
      cyc(2);

      // Directed values, including boundaries
      run_op(8'h05, 8'h03);
      run_op(8'h03, 8'h05);
      run_op(8'h00, 8'hFF);
      run_op(8'h80, 8'h01);
      run_op(8'h7F, 8'hFF);
      run_op(8'h00, 8'h00);
      run_op(8'h5A, 8'h5A);
      run_op(8'hFF, 8'h00);
      run_op(8'h01, 8'h80);

      for (int i = 0; i < 16; i++) begin
         run_op(8'($urandom), 8'($urandom));
      end

      // Start during RUN is ignored; operands churn during RUN
      a     = 8'h05;
      b     = 8'h03;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         a     = 8'($urandom);
         b     = 8'($urandom);
         start = (i == 3);
         if (i == 3) begin
            a = 8'hAA;
            b = 8'h11;
         end
         cyc(1);
      end
      start = 1'b0;
      cyc(2);

      // Reset mid-RUN aborts; next operation is fresh
      a     = 8'h10;
      b     = 8'h01;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(3);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      run_op(8'h10, 8'h01);

      // Start held high: accepted only in IDLE
      start = 1'b1;
      for (int i = 0; i < 4 * (W + 2); i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         cyc(1);
      end
      start = 1'b0;
      cyc(W + 4);

      check("queue_drained", 32'(q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: start  input  1  request to begin one subtraction.
REQ-006 Port: a  input  WIDTH  minuend, sampled only when start is accepted.
REQ-007 Port: b  input  WIDTH  subtrahend, sampled only when start is accepted.
REQ-008 Port: busy  output  1  high while a subtraction is in progress.
REQ-009 Port: done  output  1  one-cycle pulse marking that the result is valid.
REQ-010 Port: diff  output  WIDTH  result a-b, modulo 2^WIDTH.
REQ-011 Port: borrow_out  output  1  final borrow; high when unsigned a < b.
REQ-012 Port: ovf  output  1  two's-complement overflow of a-b.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 Start SHALL be accepted only in IDLE.
- On acceptance: a and b latched, internal borrow cleared to 0, bit counter cleared to 0, state goes to RUN.
REQ-015 In RUN, each clock edge SHALL process exactly one bit, LSB first, at index = counter.
- Difference bit = a_i XOR b_i XOR bin.
- Next borrow = (NOT a_i AND b_i) OR (NOT(a_i XOR b_i) AND bin).
- The difference bit is stored at diff[counter]; the counter then increments.
REQ-016 The edge that processes bit WIDTH-1 SHALL move the state to DONE.
- On that same edge, borrow_out takes the final borrow.
- On that same edge, ovf = (a[W-1] != b[W-1]) AND (diff[W-1] != a[W-1]).
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE on the next edge.
REQ-018 Latency: if start is high in IDLE in cycle k, then:
- busy SHALL be 1 in cycles k+1..k+WIDTH;
- done SHALL be 1 in cycle k+WIDTH+1;
- the block SHALL be in IDLE in cycle k+WIDTH+2.
REQ-019 busy SHALL be 1 exactly in the RUN state, and done SHALL be 1 exactly in the DONE state.
REQ-020 Start asserted in RUN or DONE SHALL be ignored, with no effect on the operands, counter, borrow or outputs. Start is not queued.
REQ-021 diff, borrow_out and ovf SHALL hold their last completed values until the next accepted start. From that start they may change bit by bit during RUN and are defined only in the done cycle.
REQ-022 a and b SHALL be allowed to change freely after the start cycle without affecting the result in progress.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH with no saturation.
- 0-0 gives 0.
- Equal operands give 0 with borrow_out=0.
- 0 minus all-ones gives 1 with borrow_out=1.
REQ-024 The counter SHALL be wide enough to hold WIDTH-1 and SHALL NOT wrap during RUN.

Reset
REQ-025 When rst_n=0 at a rising edge, the following SHALL apply regardless of state:
- state goes to IDLE;
- busy=0, done=0, diff=0, borrow_out=0, ovf=0;
- counter=0 and internal borrow=0.
REQ-026 Reset SHALL take priority over start; start sampled in the same edge as rst_n=0 SHALL be discarded.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start accepted after rst_n returns high SHALL behave as a fresh operation.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start for 1 cycle -> busy for 8 cycles, then done pulse with diff=0x02, borrow_out=0, ovf=0.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, ovf=0. Also a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
REQ-030 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
REQ-031 Start 0x05-0x03, then pulse start with a=0xAA, b=0x11 in cycle k+3 and change a and b during RUN -> single done in cycle k+9, with diff=0x02.
REQ-032 Start 0x10-0x01, drive rst_n=0 at cycle k+4 for 1 cycle:
- no done pulse;
- all outputs 0;
- the next start of 0x10-0x01 gives diff=0x0F at the correct latency.
REQ-033 Back-to-back: start held high continuously -> a new operation is accepted every WIDTH+2 cycles (in IDLE only), with one done per operation.
